pc_breakpoint_trace: RTL and testbench

- Debug monitor inside the Niski SoC, beside the RISC-V core.
- Watches the retiring program counter and compares it against NUM_BP programmable breakpoint addresses. On a match it raises a halt request to the core.
- Keeps a circular trace buffer of the most recent TRACE_DEPTH retired PCs, readable by the debug host.
- Generalises the single hard-coded stop address used in simulation into N runtime channels plus a hardware PC history.

---
 rtl/pc_breakpoint_trace.sv | 224 ++++++++++++++++++++++
 tb/tb_pc_breakpoint_trace.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_breakpoint_trace.sv
// Retired-PC breakpoint monitor with halt/resume FSM and a circular PC trace buffer.
// Define NISKI_TRACE_TIMESTAMP_EN to store a 16-bit cycle timestamp with every trace entry.
module pc_breakpoint_trace #(
    parameter int ADDR_W       = 32,
    parameter int NUM_BP       = 4,
    parameter int TRACE_DEPTH  = 16,
    localparam int IDX_W       = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
    localparam int PTR_W       = $clog2(TRACE_DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic              cfg_en,
    output logic              halt,
    output logic [IDX_W-1:0]  hit_idx,
    input  logic              resume,
    input  logic              trace_rd,
    output logic [ADDR_W-1:0] trace_data,
    output logic [15:0]       trace_ts,
    output logic              trace_empty,
    output logic [CNT_W-1:0]  trace_count,
    output logic              trace_ovf
);
    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_skip;
    logic                w_skip_nxt;
    logic                r_halt;
    logic [IDX_W-1:0]    r_hit_idx;
    logic [IDX_W-1:0]    w_hit_idx_nxt;
    logic [ADDR_W-3:0]   r_bp_addr [NUM_BP];
    logic [NUM_BP-1:0]   r_bp_en;
    logic [NUM_BP-1:0]   w_hit_vec;
    logic                w_any_hit;
    logic [IDX_W-1:0]    w_hit_sel;
    logic                w_unused;

    logic [ADDR_W-1:0]   r_mem [TRACE_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                r_empty;
    logic                r_ovf;
    logic [ADDR_W-1:0]   r_trace_data;
    logic                w_full;
    logic                w_rd_ok;
    logic                w_overwrite;

    // Word-aligned compare: the two low address bits never take part in matching.
    assign w_unused = ^cfg_addr[1:0];

    // Breakpoint channel configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BP; i++) begin
                r_bp_addr[i] <= '0;
            end
            r_bp_en <= '0;
        end else if (cfg_we && (int'(cfg_idx) < NUM_BP)) begin
            r_bp_addr[cfg_idx] <= cfg_addr[ADDR_W-1:2];
            r_bp_en[cfg_idx]   <= cfg_en;
        end
    end

    // Per-channel match and lowest-index priority select
    always_comb begin
        w_hit_sel = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            w_hit_vec[i] = r_bp_en[i] & pc_valid & (pc[ADDR_W-1:2] == r_bp_addr[i]);
        end
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            w_hit_sel = w_hit_vec[i] ? IDX_W'(i) : w_hit_sel;
        end
        w_any_hit = |w_hit_vec;
    end

    // Halt FSM next state; a pending skip swallows exactly one retired PC after resume
    always_comb begin
        w_state_nxt   = r_state;
        w_skip_nxt    = r_skip;
        w_hit_idx_nxt = r_hit_idx;
        case (r_state)
            ST_RUN: begin
                if (pc_valid && r_skip) begin
                    w_skip_nxt = 1'b0;
                end else if (w_any_hit) begin
                    w_state_nxt   = ST_HALTED;
                    w_hit_idx_nxt = w_hit_sel;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    w_state_nxt = ST_RUN;
                    w_skip_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_HALTED;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_skip_nxt  = 1'b0;
            end
        endcase
    end

    // Halt FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_skip    <= 1'b0;
            r_hit_idx <= '0;
            r_halt    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_skip    <= w_skip_nxt;
            r_hit_idx <= w_hit_idx_nxt;
            r_halt    <= (w_state_nxt == ST_HALTED);
        end
    end

    assign w_full      = (r_count == CNT_W'(TRACE_DEPTH));
    assign w_rd_ok     = trace_rd && !r_empty;
    assign w_overwrite = pc_valid && w_full && !w_rd_ok;

    // Occupancy: a write into a full buffer replaces the oldest entry instead of growing
    always_comb begin
        w_count_nxt = r_count;
        if (pc_valid && !w_rd_ok && !w_full) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!pc_valid && w_rd_ok) begin
            w_count_nxt = r_count - CNT_W'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Trace pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            if (pc_valid) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_ok || w_overwrite) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_overwrite) begin
                r_ovf <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Trace storage; stale contents are unreachable once the pointers reset
    always_ff @(posedge clk) begin
        if (pc_valid) begin
            r_mem[r_wr_ptr] <= pc;
        end
    end

    // Show-ahead head entry, forced to zero while the buffer is empty
    always_ff @(posedge clk) begin
        if (rst || r_empty) begin
            r_trace_data <= '0;
        end else begin
            r_trace_data <= r_mem[r_rd_ptr];
        end
    end

`ifdef NISKI_TRACE_TIMESTAMP_EN
    logic [15:0] r_cyc;
    logic [15:0] r_ts_mem [TRACE_DEPTH];
    logic [15:0] r_trace_ts;

    // Free-running cycle counter and per-entry timestamp storage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc <= 16'd0;
        end else begin
            r_cyc <= r_cyc + 16'd1;
        end
        if (pc_valid) begin
            r_ts_mem[r_wr_ptr] <= r_cyc;
        end
    end

    // Timestamp of the head entry, aligned with trace_data
    always_ff @(posedge clk) begin
        if (rst || r_empty) begin
            r_trace_ts <= 16'd0;
        end else begin
            r_trace_ts <= r_ts_mem[r_rd_ptr];
        end
    end

    assign trace_ts = r_trace_ts;
`else
    assign trace_ts = 16'd0;
`endif

    assign halt        = r_halt;
    assign hit_idx     = r_hit_idx;
    assign trace_data  = r_trace_data;
    assign trace_empty = r_empty;
    assign trace_count = r_count;
    assign trace_ovf   = r_ovf;

endmodule

// File: tb/tb_pc_breakpoint_trace.sv
// Bench for pc_breakpoint_trace: directed vector table, multi-cycle corner sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_pc_breakpoint_trace;
    localparam int ADDR_W      = 32;
    localparam int NUM_BP      = 6;
    localparam int TRACE_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, pc_valid, cfg_we, cfg_en, resume, trace_rd;
    logic [31:0] pc, cfg_addr;
    logic [2:0]  cfg_idx, hit_idx;
    logic        halt, trace_empty, trace_ovf;
    logic [31:0] trace_data;
    logic [15:0] trace_ts;
    logic [4:0]  trace_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_breakpoint_trace #(.ADDR_W(ADDR_W), .NUM_BP(NUM_BP), .TRACE_DEPTH(TRACE_DEPTH)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
        .halt(halt), .hit_idx(hit_idx), .resume(resume), .trace_rd(trace_rd),
        .trace_data(trace_data), .trace_ts(trace_ts), .trace_empty(trace_empty),
        .trace_count(trace_count), .trace_ovf(trace_ovf)
    );

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic        we;
        logic [2:0]  idx;
        logic [31:0] ca;
        logic        en;
        logic        res;
        logic        e_halt;
        logic [2:0]  e_hit;
        logic [4:0]  e_cnt;
    } vec_t;
    vec_t tbl [$];

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] ts;
    } ent_t;

    // reference model state
    logic [31:0] m_addr [NUM_BP];
    logic        m_en   [NUM_BP];
    logic        m_halt, m_skip, m_ovf;
    logic [2:0]  m_hit;
    logic [15:0] m_cyc;
    ent_t        m_q [$];
    logic [31:0] exp_data;
    logic [15:0] exp_ts;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; pc_valid = 1'b0; pc = 32'h0; cfg_we = 1'b0; cfg_idx = 3'd0;
        cfg_addr = 32'h0; cfg_en = 1'b0; resume = 1'b0; trace_rd = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] a);
        pc_valid = 1'b1; pc = a;
        step();
        pc_valid = 1'b0;
    endtask

    task automatic cfg(input logic [2:0] idx, input logic [31:0] a, input logic en);
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_en = en;
        step();
        cfg_we = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 32'h40001594;
            1:       return 32'h40000010;
            2:       return 32'h40000013;
            3:       return 32'h00000100;
            4:       return 32'h40001596;
            default: return 32'($urandom());
        endcase
    endfunction

    task automatic model_reset();
        m_halt = 1'b0; m_skip = 1'b0; m_ovf = 1'b0; m_hit = 3'd0; m_cyc = 16'd0;
        m_q.delete();
        exp_data = 32'h0; exp_ts = 16'd0;
        for (int i = 0; i < NUM_BP; i++) begin
            m_addr[i] = 32'h0;
            m_en[i]   = 1'b0;
        end
    endtask

    task automatic model_update();
        logic found;
        logic [2:0] sel;
        ent_t e;
        if (rst) begin
            model_reset();
        end else begin
            exp_data = (m_q.size() == 0) ? 32'h0 : m_q[0].pc;
            exp_ts   = (m_q.size() == 0) ? 16'd0 : m_q[0].ts;
            found = 1'b0; sel = 3'd0;
            for (int i = 0; i < NUM_BP; i++) begin
                if (!found && m_en[i] && pc_valid && pc[31:2] == m_addr[i][31:2]) begin
                    found = 1'b1; sel = 3'(i);
                end
            end
            if (!m_halt) begin
                if (pc_valid && m_skip) m_skip = 1'b0;
                else if (found) begin m_halt = 1'b1; m_hit = sel; end
            end else if (resume) begin
                m_halt = 1'b0; m_skip = 1'b1;
            end
            if (cfg_we && int'(cfg_idx) < NUM_BP) begin
                m_addr[int'(cfg_idx)] = cfg_addr;
                m_en[int'(cfg_idx)]   = cfg_en;
            end
            if (trace_rd && m_q.size() > 0) void'(m_q.pop_front());
            if (pc_valid) begin
                if (m_q.size() == TRACE_DEPTH) begin
                    void'(m_q.pop_front());
                    m_ovf = 1'b1;
                end
                e.pc = pc; e.ts = m_cyc;
                m_q.push_back(e);
            end
            m_cyc = m_cyc + 16'd1;
        end
    endtask

    initial begin
        idle_inputs();
        //                 v     pc            we    idx   cfg_addr      en    res  | halt  hit   cnt
        tbl.push_back('{1'b0, 32'h0,        1'b1, 3'd2, 32'h40001594, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0});
        tbl.push_back('{1'b1, 32'h40001590, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 5'd1});
        tbl.push_back('{1'b1, 32'h40001594, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd2, 5'd2});
        tbl.push_back('{1'b0, 32'h0,        1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd2, 5'd2});
        tbl.push_back('{1'b0, 32'h0,        1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 1'b0, 3'd2, 5'd2});
        tbl.push_back('{1'b1, 32'h40001594, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd2, 5'd3});
        tbl.push_back('{1'b1, 32'h40001594, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd2, 5'd4});
        tbl.push_back('{1'b0, 32'h0,        1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 1'b0, 3'd2, 5'd4});
        tbl.push_back('{1'b1, 32'h40001000, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd2, 5'd5});
        tbl.push_back('{1'b0, 32'h0,        1'b1, 3'd0, 32'h40000010, 1'b1, 1'b0, 1'b0, 3'd2, 5'd5});
        tbl.push_back('{1'b0, 32'h0,        1'b1, 3'd3, 32'h40000013, 1'b1, 1'b0, 1'b0, 3'd2, 5'd5});
        tbl.push_back('{1'b1, 32'h40000010, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd0, 5'd6});
        tbl.push_back('{1'b1, 32'h40000010, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd0, 5'd7});
        tbl.push_back('{1'b0, 32'h0,        1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 1'b0, 3'd0, 5'd7});
        tbl.push_back('{1'b0, 32'h0,        1'b1, 3'd0, 32'h40000010, 1'b0, 1'b0, 1'b0, 3'd0, 5'd7});
        tbl.push_back('{1'b1, 32'h40000010, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 5'd8});
        tbl.push_back('{1'b1, 32'h40000012, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd3, 5'd9});
        tbl.push_back('{1'b1, 32'h40000010, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 1'b0, 3'd3, 5'd10});
        tbl.push_back('{1'b1, 32'h00000000, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd3, 5'd11});
        tbl.push_back('{1'b1, 32'h40000010, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 1'b1, 3'd3, 5'd12});
        tbl.push_back('{1'b0, 32'h0,        1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd3, 5'd12});
        tbl.push_back('{1'b0, 32'h0,        1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 1'b0, 3'd3, 5'd12});

        // reset state
        do_reset();
        check("rst_halt",  32'(halt), 32'd0);
        check("rst_hit",   32'(hit_idx), 32'd0);
        check("rst_data",  trace_data, 32'h0);
        check("rst_ts",    32'(trace_ts), 32'd0);
        check("rst_empty", 32'(trace_empty), 32'd1);
        check("rst_count", 32'(trace_count), 32'd0);
        check("rst_ovf",   32'(trace_ovf), 32'd0);

        // breakpoint hit, priority and resume-skip vectors
        for (int k = 0; k < tbl.size(); k++) begin
            pc_valid = tbl[k].v; pc = tbl[k].a; cfg_we = tbl[k].we; cfg_idx = tbl[k].idx;
            cfg_addr = tbl[k].ca; cfg_en = tbl[k].en; resume = tbl[k].res;
            step();
            check($sformatf("row%0d_halt", k), 32'(halt), 32'(tbl[k].e_halt));
            check($sformatf("row%0d_hit", k), 32'(hit_idx), 32'(tbl[k].e_hit));
            check($sformatf("row%0d_count", k), 32'(trace_count), 32'(tbl[k].e_cnt));
        end
        idle_inputs();

        // trace overflow and draining
        do_reset();
        for (int k = 0; k < 20; k++) strobe(32'h100 + 32'(4 * k));
        check("ovf_count", 32'(trace_count), 32'd16);
        check("ovf_flag",  32'(trace_ovf), 32'd1);
        check("ovf_empty", 32'(trace_empty), 32'd0);
        step();
        for (int k = 0; k < 16; k++) begin
            check($sformatf("pop%0d_data", k), trace_data, 32'h110 + 32'(4 * k));
            trace_rd = 1'b1; step(); trace_rd = 1'b0; step();
        end
        check("drain_empty", 32'(trace_empty), 32'd1);
        check("drain_count", 32'(trace_count), 32'd0);
        trace_rd = 1'b1; step(); trace_rd = 1'b0;
        check("pop17_empty", 32'(trace_empty), 32'd1);
        check("pop17_count", 32'(trace_count), 32'd0);
        check("pop17_ovf",   32'(trace_ovf), 32'd1);
        check("pop17_data",  trace_data, 32'h0);

        // reset while halted with five entries
        cfg(3'd1, 32'h500, 1'b1);
        strobe(32'h600); strobe(32'h604); strobe(32'h608); strobe(32'h60C); strobe(32'h500);
        check("pre_rst_halt",  32'(halt), 32'd1);
        check("pre_rst_count", 32'(trace_count), 32'd5);
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst_halt",  32'(halt), 32'd0);
        check("midrst_hit",   32'(hit_idx), 32'd0);
        check("midrst_empty", 32'(trace_empty), 32'd1);
        check("midrst_count", 32'(trace_count), 32'd0);
        check("midrst_ovf",   32'(trace_ovf), 32'd0);
        strobe(32'h500);
        check("midrst_nohalt", 32'(halt), 32'd0);
        check("midrst_count1", 32'(trace_count), 32'd1);
        step();
        check("midrst_data", trace_data, 32'h500);
`ifdef NISKI_TRACE_TIMESTAMP_EN
        check("midrst_ts_small", 32'(trace_ts < 16'd16), 32'd1);
`else
        check("midrst_ts_zero", 32'(trace_ts), 32'd0);
`endif

        // boundaries: read+write on empty, out-of-range config, channel disable
        do_reset();
        trace_rd = 1'b1; pc_valid = 1'b1; pc = 32'h200;
        step();
        idle_inputs();
        check("rw_empty_count", 32'(trace_count), 32'd1);
        check("rw_empty_flag",  32'(trace_empty), 32'd0);
        step();
        check("rw_empty_data", trace_data, 32'h200);
        cfg(3'd6, 32'h300, 1'b1);
        cfg(3'd7, 32'h300, 1'b1);
        strobe(32'h300);
        check("oor_nohalt", 32'(halt), 32'd0);
        cfg(3'd2, 32'h40001594, 1'b1);
        strobe(32'h40001594);
        check("ch2_halt", 32'(halt), 32'd1);
        check("ch2_hit",  32'(hit_idx), 32'd2);
        resume = 1'b1; step(); resume = 1'b0;
        strobe(32'h700);
        cfg(3'd2, 32'h40001594, 1'b0);
        strobe(32'h40001594);
        check("dis_nohalt", 32'(halt), 32'd0);

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            rst      = ($urandom_range(0, 499) == 0);
            pc_valid = 1'($urandom_range(0, 1));
            pc       = pick_addr();
            cfg_we   = ($urandom_range(0, 15) == 0);
            cfg_idx  = 3'($urandom_range(0, 7));
            cfg_addr = pick_addr();
            cfg_en   = ($urandom_range(0, 3) != 0);
            resume   = ($urandom_range(0, 5) == 0);
            trace_rd = ($urandom_range(0, 2) == 0);
            model_update();
            step();
            check("rnd_halt",  32'(halt), 32'(m_halt));
            check("rnd_hit",   32'(hit_idx), 32'(m_hit));
            check("rnd_count", 32'(trace_count), 32'(m_q.size()));
            check("rnd_empty", 32'(trace_empty), 32'(m_q.size() == 0));
            check("rnd_ovf",   32'(trace_ovf), 32'(m_ovf));
            check("rnd_data",  trace_data, exp_data);
`ifdef NISKI_TRACE_TIMESTAMP_EN
            check("rnd_ts", 32'(trace_ts), 32'(exp_ts));
`else
            check("rnd_ts", 32'(trace_ts), 32'd0);
`endif
        end
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
